// File: rtl/ram_fifo_pkg.sv
// Shared types and helpers for the RAM-backed FIFO controller.
package ram_fifo_pkg;

    // Per-cycle decision for the single RAM port
    typedef enum logic [1:0] {
        OP_IDLE,
        OP_WR,
        OP_RD
    } ram_op_t;

    // Number of words the RAM holds for a given address width
    function automatic int unsigned fifo_depth(input int unsigned addr_width);
        return 32'd1 << addr_width;
    endfunction

endpackage

// File: rtl/ram_fifo_ctrl.sv
// Controller that runs a separate-I/O single-port RAM as a circular FIFO:
// write/read pointers, full/empty, port arbitration and a one-word output
// register fed from the RAM's registered read data.
module ram_fifo_ctrl
    import ram_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic [ADDR_WIDTH:0]   count
);

    localparam int unsigned PTR_W = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH:0] DEPTH = PTR_W'(fifo_depth(ADDR_WIDTH));

    logic [ADDR_WIDTH:0] wr_ptr;
    logic [ADDR_WIDTH:0] rd_ptr;
    logic                rd_pend;
    logic                empty;
    logic                full;
    logic                out_free;
    logic                rd_issue;
    ram_op_t             op;

    // Extra pointer MSB distinguishes full from empty
    assign count    = wr_ptr - rd_ptr;
    assign empty    = (count == '0);
    assign full     = (count == DEPTH);
    assign out_free = !out_valid || out_ready;

    // A read needs a word, no read in flight and room in the output register;
    // the rd_pend term limits reads to every other cycle so writes get a turn
    assign rd_issue = !rst && !empty && !rd_pend && out_free;
    assign in_ready = !rst && !full && !rd_issue;

    // Arbitrate the single RAM port: reads win, writes take the rest
    always_comb begin
        op = OP_IDLE;
        if (rd_issue) begin
            op = OP_RD;
        end else if (in_valid && in_ready) begin
            op = OP_WR;
        end
    end

    // Drive the RAM port from the arbitration decision; idle parks on rd_ptr
    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (!rst) begin
            if (op == OP_WR) begin
                ram_we    = 1'b1;
                ram_addr  = wr_ptr[ADDR_WIDTH-1:0];
                ram_wdata = in_data;
            end else begin
                ram_addr  = rd_ptr[ADDR_WIDTH-1:0];
            end
        end
    end

    // Pointer advance, read-pending tracking and output register load/drain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            rd_pend   <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (op == OP_WR) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (op == OP_RD) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            rd_pend <= (op == OP_RD);
            // A load only follows a read issued into a free register, so it
            // may safely override the drain
            if (rd_pend) begin
                out_data  <= ram_rdata;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
